// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The source/sink side drives the master modport; the ALU itself uses slave.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, flags, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, flags, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with registered result and flags {overflow, negative, carry, zero}.
// Also provides an iterative shift-add multiplier and an internal accumulator.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]     y_r;
    logic [3:0]           flags_r;
    logic                 err_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [CW-1:0]        cnt_r;
    logic                 mul_hi_r;

    logic                 accept_s;
    logic                 is_mul_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [WIDTH:0]       acc_add_s;
    logic [WIDTH:0]       acc_sub_s;
    logic [WIDTH-1:0]     res_y_s;
    logic                 res_c_s;
    logic                 res_v_s;
    logic                 res_err_s;
    logic [WIDTH-1:0]     acc_nxt_s;
    logic [2*WIDTH-1:0]   prod_nxt_s;
    logic [WIDTH-1:0]     mul_y_s;
    logic                 mul_c_s;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == z[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z,
                                     input logic [WIDTH-1:0] d);
        return (x[WIDTH-1] != z[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Illegal ops report all-zero flags even though y is zero.
    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] yv, input logic c,
                                              input logic v, input logic e);
        if (e) begin
            return 4'b0000;
        end else begin
            return {v, yv[WIDTH-1], c, (yv == {WIDTH{1'b0}})};
        end
    endfunction

    assign bus.in_ready  = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.flags     = flags_r;
    assign bus.err       = err_r;

    assign accept_s  = bus.in_valid && bus.in_ready;
    assign is_mul_s  = (bus.op[3:1] == 3'b100);
    assign add_s     = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_s     = {1'b0, bus.a} - {1'b0, bus.b};
    assign acc_add_s = {1'b0, acc_r} + {1'b0, bus.a};
    assign acc_sub_s = {1'b0, acc_r} - {1'b0, bus.a};

    // Single-cycle result of every non-multiply op, plus the accumulator's next value.
    always_comb begin
        res_y_s   = {WIDTH{1'b0}};
        res_c_s   = 1'b0;
        res_v_s   = 1'b0;
        res_err_s = 1'b0;
        acc_nxt_s = acc_r;
        case (bus.op)
            4'b0000: res_y_s = bus.b;
            4'b0001: begin
                res_y_s = {bus.a[WIDTH-2:0], 1'b0};
                res_c_s = bus.a[WIDTH-1];
            end
            4'b0010: res_y_s = bus.a | bus.b;
            4'b0011: begin
                res_y_s = sub_s[WIDTH-1:0];
                res_c_s = sub_s[WIDTH];
                res_v_s = sub_ovf(bus.a, bus.b, sub_s[WIDTH-1:0]);
            end
            4'b0100: res_y_s = bus.a ^ bus.b;
            4'b0101: res_y_s = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            4'b0110: res_y_s = bus.a & bus.b;
            4'b0111: begin
                res_y_s = add_s[WIDTH-1:0];
                res_c_s = add_s[WIDTH];
                res_v_s = add_ovf(bus.a, bus.b, add_s[WIDTH-1:0]);
            end
            4'b1000, 4'b1001: res_y_s = {WIDTH{1'b0}};
            4'b1010: begin
                res_y_s   = bus.a;
                acc_nxt_s = bus.a;
            end
            4'b1011: begin
                res_y_s   = acc_add_s[WIDTH-1:0];
                res_c_s   = acc_add_s[WIDTH];
                res_v_s   = add_ovf(acc_r, bus.a, acc_add_s[WIDTH-1:0]);
                acc_nxt_s = acc_add_s[WIDTH-1:0];
            end
            4'b1100: begin
                res_y_s   = acc_sub_s[WIDTH-1:0];
                res_c_s   = acc_sub_s[WIDTH];
                res_v_s   = sub_ovf(acc_r, bus.a, acc_sub_s[WIDTH-1:0]);
                acc_nxt_s = acc_sub_s[WIDTH-1:0];
            end
            default: res_err_s = 1'b1;
        endcase
    end

    // Multiplier step: the final step's partial product is the finished product.
    always_comb begin
        prod_nxt_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
        if (mul_hi_r) begin
            mul_y_s = prod_nxt_s[2*WIDTH-1:WIDTH];
            mul_c_s = 1'b0;
        end else begin
            mul_y_s = prod_nxt_s[WIDTH-1:0];
            mul_c_s = (prod_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        end
    end

    // Control FSM with registered result, accumulator and multiplier datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            mcand_r     <= {(2*WIDTH){1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            prod_r      <= {(2*WIDTH){1'b0}};
            cnt_r       <= {CW{1'b0}};
            mul_hi_r    <= 1'b0;
        end else if (accept_s) begin
            if (is_mul_s) begin
                mcand_r     <= {{WIDTH{1'b0}}, bus.a};
                mplier_r    <= bus.b;
                prod_r      <= {(2*WIDTH){1'b0}};
                cnt_r       <= {CW{1'b0}};
                mul_hi_r    <= bus.op[0];
                out_valid_r <= 1'b0;
                state_r     <= BUSY;
            end else begin
                y_r         <= res_y_s;
                flags_r     <= pack_flags(res_y_s, res_c_s, res_v_s, res_err_s);
                err_r       <= res_err_s;
                acc_r       <= acc_nxt_s;
                out_valid_r <= 1'b1;
                state_r     <= DONE;
            end
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                BUSY: begin
                    prod_r   <= prod_nxt_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        y_r         <= mul_y_s;
                        flags_r     <= pack_flags(mul_y_s, mul_c_s, 1'b0, 1'b0);
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed cases plus random ops
// checked against an integer-arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 8;
    localparam int M = 256;
    localparam int H = 128;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_acc = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sg(input int x);
        return (x >= H) ? x - M : x;
    endfunction

    function automatic int ovf(input int s);
        return (s > H - 1 || s < -H) ? 1 : 0;
    endfunction

    // Reference model: plain integer arithmetic; updates m_acc for accumulator ops.
    task automatic model(input int op, input int a, input int b,
                         output int y, output int fl, output int e);
        int c, v, s, ng, z;
        c = 0; v = 0; e = 0; y = 0;
        case (op)
            0: y = b;
            1: begin y = (a * 2) % M; c = (a >= H) ? 1 : 0; end
            2: y = a | b;
            3: begin y = (a - b + M) % M; c = (a < b) ? 1 : 0; v = ovf(sg(a) - sg(b)); end
            4: y = a ^ b;
            5: y = (a > b) ? 1 : 0;
            6: y = a & b;
            7: begin s = a + b; y = s % M; c = (s >= M) ? 1 : 0; v = ovf(sg(a) + sg(b)); end
            8: begin y = (a * b) % M; c = ((a * b) / M != 0) ? 1 : 0; end
            9: y = (a * b) / M;
            10: begin m_acc = a; y = a; end
            11: begin
                s = m_acc + a; y = s % M; c = (s >= M) ? 1 : 0;
                v = ovf(sg(m_acc) + sg(a)); m_acc = y;
            end
            12: begin
                y = (m_acc - a + M) % M; c = (m_acc < a) ? 1 : 0;
                v = ovf(sg(m_acc) - sg(a)); m_acc = y;
            end
            default: e = 1;
        endcase
        ng = (y >= H) ? 1 : 0;
        z  = (y == 0) ? 1 : 0;
        fl = e ? 0 : (v * 8 + ng * 4 + c * 2 + z);
    endtask

    // Issue one op from IDLE/draining state, wait (bounded) for its result, check it.
    task automatic run_op(input int op, input int a, input int b);
        int ey, ef, ee, lat;
        bit mul;
        mul = (op == 8 || op == 9);
        model(op, a, b, ey, ef, ee);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op[3:0];
        bus.a  = a[W-1:0];
        bus.b  = b[W-1:0];
        check($sformatf("in_ready_op%0d", op), bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        if (mul) check("in_ready_busy", bus.in_ready, 0);
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency_op%0d", op), lat, mul ? W + 1 : 1);
        check($sformatf("y_op%0d_a%0d_b%0d", op, a, b), bus.y, ey);
        check($sformatf("flags_op%0d_a%0d_b%0d", op, a, b), bus.flags, ef);
        check($sformatf("err_op%0d", op), bus.err, ee);
    endtask

    task automatic expect_now(input string tag, input int y, input int fl, input int e);
        check({tag, "_y"}, bus.y, y);
        check({tag, "_flags"}, bus.flags, fl);
        check({tag, "_err"}, bus.err, e);
    endtask

    initial begin
        int op, a, b, ey, ef, ee, hy, hf;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 4'd0;
        bus.a = '0;
        bus.b = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        expect_now("rst", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", bus.in_ready, 1);

        run_op(7, 200, 100);  expect_now("add_200_100", 44, 2, 0);
        run_op(3, 128, 1);    expect_now("sub_ovf", 127, 8, 0);
        run_op(3, 1, 2);      expect_now("sub_borrow", 255, 6, 0);
        run_op(8, 200, 200);  expect_now("mullo_200", 64, 2, 0);
        run_op(9, 200, 200);  expect_now("mulhi_200", 156, 4, 0);
        run_op(8, 15, 17);    expect_now("mullo_15_17", 255, 4, 0);
        run_op(10, 10, 0);    expect_now("acc_ld", 10, 0, 0);
        run_op(11, 250, 0);   expect_now("acc_add", 4, 2, 0);
        run_op(12, 5, 0);     expect_now("acc_sub", 255, 6, 0);
        run_op(13, 9, 9);     expect_now("illegal", 0, 0, 1);
        run_op(11, 1, 0);     expect_now("acc_add_wrap", 0, 3, 0);

        for (int i = 0; i < 60; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Back-to-back stream, one op per cycle, no multiplies.
        for (int i = 0; i < 12; i++) begin
            op = $urandom_range(0, 13);
            if (op == 8 || op == 9) op = op + 6;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            model(op, a, b, ey, ef, ee);
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op = op[3:0];
            bus.a = a[W-1:0];
            bus.b = b[W-1:0];
            @(posedge clk);
            #1;
            check("b2b_out_valid", bus.out_valid, 1);
            expect_now($sformatf("b2b_op%0d", op), ey, ef, ee);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;

        // Backpressure: hold result for 5 cycles, then drain and accept together.
        @(negedge clk);
        bus.out_ready = 1'b0;
        model(7, 1, 2, hy, hf, ee);
        bus.in_valid = 1'b1;
        bus.op = 4'd7;
        bus.a = 8'd1;
        bus.b = 8'd2;
        @(posedge clk);
        #1;
        check("bp_first_valid", bus.out_valid, 1);
        bus.op = 4'd0;
        bus.b = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            expect_now("bp_hold", hy, hf, 0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        model(0, 1, 85, ey, ef, ee);
        #1 check("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_accept_valid", bus.out_valid, 1);
        expect_now("bp_accept", ey, ef, ee);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'd8;
        bus.a = 8'd7;
        bus.b = 8'd9;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        m_acc = 0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        expect_now("midrst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        run_op(11, 5, 0);  expect_now("post_rst_acc", 5, 0, 0);
        run_op(7, 3, 4);   expect_now("post_rst_add", 7, 0, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
